// File: rtl/param_frame_tx_pkg.sv
// Shared definitions for the frequency-sweep parameter link (TX framer and RX rebuild FSM).
// Holds frame tags, frame length, state encoding and the byte-position mux.
package param_frame_tx_pkg;

  localparam logic [7:0] TAG_MAX   = 8'h01;
  localparam logic [7:0] TAG_MIN   = 8'h02;
  localparam logic [7:0] TAG_STEP  = 8'h03;
  localparam int         FRAME_LEN = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } frame_state_t;

  // Byte at position idx of a frame: tag followed by the value MSB first.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [23:0] max_word,
    input logic [23:0] min_word,
    input logic [23:0] step_word
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = TAG_MAX;
      4'd1:    b = max_word[23:16];
      4'd2:    b = max_word[15:8];
      4'd3:    b = max_word[7:0];
      4'd4:    b = TAG_MIN;
      4'd5:    b = min_word[23:16];
      4'd6:    b = min_word[15:8];
      4'd7:    b = min_word[7:0];
      4'd8:    b = TAG_STEP;
      4'd9:    b = step_word[23:16];
      4'd10:   b = step_word[15:8];
      4'd11:   b = step_word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/param_frame_tx.sv
// Transmit-side framer: snapshots max/min/step on start and feeds a 12-byte
// tagged frame to an external byte-wide UART TX with an inter-byte gap and done timeout.
module param_frame_tx
  import param_frame_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned DONE_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic        start,
  input  logic [23:0] fre_max,
  input  logic [23:0] fre_min,
  input  logic [23:0] fre_step,
  input  logic        TX_Done_Sig,
  output logic        TX_En_Sig,
  output logic [7:0]  TX_Data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [3:0]  LAST_IDX   = 4'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_LOAD   = 8'(GAP_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(DONE_TIMEOUT - 1);
  localparam logic        TO_ENABLED = (DONE_TIMEOUT != 0);

  frame_state_t state;
  logic [3:0]   idx;
  logic [23:0]  snap_max;
  logic [23:0]  snap_min;
  logic [23:0]  snap_step;
  logic [7:0]   gap_cnt;
  logic [31:0]  to_cnt;
  logic         timeout_hit;

  // to_cnt equals the number of SEND cycles already elapsed, so the abort is
  // decided one cycle before the registered err becomes visible.
  assign timeout_hit = TO_ENABLED && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      idx       <= 4'd0;
      snap_max  <= 24'd0;
      snap_min  <= 24'd0;
      snap_step <= 24'd0;
      gap_cnt   <= 8'd0;
      to_cnt    <= 32'd0;
      TX_En_Sig <= 1'b0;
      TX_Data   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap_max  <= fre_max;
            snap_min  <= fre_min;
            snap_step <= fre_step;
            idx       <= 4'd0;
            to_cnt    <= 32'd0;
            TX_En_Sig <= 1'b1;
            TX_Data   <= TAG_MAX;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // A completion in the same cycle as the timeout still counts as success.
          if (TX_Done_Sig) begin
            TX_En_Sig <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx     <= idx + 4'd1;
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end
          end else if (timeout_hit) begin
            TX_En_Sig <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            TX_En_Sig <= 1'b1;
            TX_Data   <= frame_byte(idx, snap_max, snap_min, snap_step);
            to_cnt    <= 32'd0;
            state     <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
